// File: rtl/dma_sequencer.sv
// dma_sequencer: SDMAC channel bus-master sequencer. It arbitrates for the
// 68030 bus (_BR/_BG/_BGACK) and issues one longword cycle per FIFO entry.
// It keeps the address and word counters and raises TC/FLUSHED/ERR status.
// Ports: CLK, _RST (sync, active-low); strobes ST_DMA/SP_DMA/FLUSH/CLR_INT;
//   config DMADIR, INTENA, WTC_IN, ACR_IN; FIFO_FULL/FIFO_EMPTY; _BG,
//   BUS_FREE, CYC_DONE in. _BR, _BGACK, CYC_REQ, CYC_RW, ADDR_OUT, WTC_OUT,
//   FIFO_PUSH, FIFO_POP, ACTIVE, TC, FLUSHED, ERR, INT out.
// Option: define DMA_TIMEOUT_EN to abort a cycle that never sees CYC_DONE.
module dma_sequencer #(
  parameter int BURST_LEN      = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        _RST,
  input  logic        ST_DMA,
  input  logic        SP_DMA,
  input  logic        FLUSH,
  input  logic        CLR_INT,
  input  logic        DMADIR,
  input  logic        INTENA,
  input  logic [23:0] WTC_IN,
  input  logic [31:0] ACR_IN,
  input  logic        FIFO_FULL,
  input  logic        FIFO_EMPTY,
  input  logic        _BG,
  input  logic        BUS_FREE,
  input  logic        CYC_DONE,
  output logic        _BR,
  output logic        _BGACK,
  output logic        CYC_REQ,
  output logic        CYC_RW,
  output logic [31:0] ADDR_OUT,
  output logic [23:0] WTC_OUT,
  output logic        FIFO_PUSH,
  output logic        FIFO_POP,
  output logic        ACTIVE,
  output logic        TC,
  output logic        FLUSHED,
  output logic        ERR,
  output logic        INT
);

  typedef enum logic [2:0] {
    IDLE, ARM, REQ, OWN, XFER, NEXT, REL
  } state_t;

  localparam logic [7:0] BLEN = 8'(BURST_LEN);

  state_t      state, state_nx;
  logic [31:0] addr, addr_nx;
  logic [23:0] wtc, wtc_nx;
  logic [7:0]  burst, burst_nx;
  logic        dir, dir_nx;
  logic        active, active_nx;
  logic        br, br_nx;
  logic        bgack, bgack_nx;
  logic        cyc_req, cyc_req_nx;
  logic        push, push_nx;
  logic        pop, pop_nx;
  logic        tc, tc_nx;
  logic        flushed, flushed_nx;
  logic        stop_pend, stop_nx;
  logic        flush_pend, fpend_nx;
  logic        tc_set, fl_set;
  logic        stop, ready, limit;
  logic        timeout;

  always_ff @(posedge CLK) begin
    if (!_RST) begin
      state      <= IDLE;
      addr       <= '0;
      wtc        <= '0;
      burst      <= '0;
      dir        <= 1'b0;
      active     <= 1'b0;
      br         <= 1'b1;
      bgack      <= 1'b1;
      cyc_req    <= 1'b0;
      push       <= 1'b0;
      pop        <= 1'b0;
      tc         <= 1'b0;
      flushed    <= 1'b0;
      stop_pend  <= 1'b0;
      flush_pend <= 1'b0;
    end else begin
      state      <= state_nx;
      addr       <= addr_nx;
      wtc        <= wtc_nx;
      burst      <= burst_nx;
      dir        <= dir_nx;
      active     <= active_nx;
      br         <= br_nx;
      bgack      <= bgack_nx;
      cyc_req    <= cyc_req_nx;
      push       <= push_nx;
      pop        <= pop_nx;
      tc         <= tc_nx;
      flushed    <= flushed_nx;
      stop_pend  <= stop_nx;
      flush_pend <= fpend_nx;
    end
  end

  // Write direction drains either a full FIFO or, while a flush is
  // pending, whatever is left in it.
  assign ready = dir ? FIFO_EMPTY
                     : (FIFO_FULL | (flush_pend & ~FIFO_EMPTY));
  assign limit = dir ? FIFO_FULL : FIFO_EMPTY;
  assign stop  = stop_pend | SP_DMA;

  always_comb begin
    state_nx   = state;
    addr_nx    = addr;
    wtc_nx     = wtc;
    burst_nx   = burst;
    dir_nx     = dir;
    active_nx  = active;
    br_nx      = br;
    bgack_nx   = bgack;
    cyc_req_nx = cyc_req;
    push_nx    = 1'b0;
    pop_nx     = 1'b0;
    stop_nx    = stop_pend;
    fpend_nx   = flush_pend;
    tc_set     = 1'b0;
    fl_set     = 1'b0;
    case (state)
      IDLE: begin
        if (ST_DMA && !SP_DMA) begin
          addr_nx = {ACR_IN[31:2], 2'b00};
          wtc_nx  = WTC_IN;
          dir_nx  = DMADIR;
          if (WTC_IN == '0) begin
            tc_set = 1'b1;
          end else begin
            state_nx  = ARM;
            active_nx = 1'b1;
          end
        end
      end
      ARM: begin
        if (SP_DMA) begin
          state_nx  = IDLE;
          active_nx = 1'b0;
          fpend_nx  = 1'b0;
        end else if (ready) begin
          state_nx = REQ;
          br_nx    = 1'b0;
        end
      end
      REQ: begin
        if (SP_DMA) begin
          state_nx  = IDLE;
          br_nx     = 1'b1;
          active_nx = 1'b0;
          fpend_nx  = 1'b0;
        end else if (!_BG && BUS_FREE) begin
          state_nx = OWN;
          br_nx    = 1'b1;
          bgack_nx = 1'b0;
          burst_nx = '0;
        end
      end
      OWN: begin
        stop_nx    = stop;
        state_nx   = XFER;
        cyc_req_nx = 1'b1;
      end
      XFER: begin
        stop_nx = stop;
        if (CYC_DONE) begin
          cyc_req_nx = 1'b0;
          addr_nx    = addr + 32'd4;
          wtc_nx     = wtc - 24'd1;
          burst_nx   = burst + 8'd1;
          push_nx    = dir;
          pop_nx     = ~dir;
          state_nx   = NEXT;
        end else if (timeout) begin
          // Abandon the cycle and leave the bus as if stopped.
          cyc_req_nx = 1'b0;
          stop_nx    = 1'b1;
          bgack_nx   = 1'b1;
          state_nx   = REL;
        end
      end
      NEXT: begin
        stop_nx = stop;
        if (wtc == '0) begin
          tc_set   = 1'b1;
          bgack_nx = 1'b1;
          state_nx = REL;
        end else if (burst == BLEN || limit || stop) begin
          bgack_nx = 1'b1;
          state_nx = REL;
        end else begin
          cyc_req_nx = 1'b1;
          state_nx   = XFER;
        end
      end
      REL: begin
        if (wtc == '0 || stop) begin
          state_nx  = IDLE;
          active_nx = 1'b0;
          stop_nx   = 1'b0;
          fpend_nx  = 1'b0;
        end else begin
          state_nx = ARM;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (flush_pend && FIFO_EMPTY &&
        (state == ARM || state == REL)) begin
      fl_set   = 1'b1;
      fpend_nx = 1'b0;
    end
    if (FLUSH) begin
      if (dir || !active) fl_set = 1'b1;
      else fpend_nx = 1'b1;
    end
    // A set event in the same cycle beats CLR_INT.
    tc_nx      = tc_set | (tc & ~CLR_INT);
    flushed_nx = fl_set | (flushed & ~CLR_INT);
  end

`ifdef DMA_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;
  logic          err;

  always_ff @(posedge CLK) begin
    if (!_RST) begin
      to_cnt <= '0;
      err    <= 1'b0;
    end else begin
      if (!cyc_req || CYC_DONE) to_cnt <= '0;
      else to_cnt <= to_cnt + 1'b1;
      err <= timeout | (err & ~CLR_INT);
    end
  end

  assign timeout = cyc_req & ~CYC_DONE &
                   (to_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign ERR = err;
`else
  assign timeout = 1'b0;
  assign ERR     = 1'b0;
`endif

  assign _BR       = br;
  assign _BGACK    = bgack;
  assign CYC_REQ   = cyc_req;
  assign CYC_RW    = dir;
  assign ADDR_OUT  = addr;
  assign WTC_OUT   = wtc;
  assign FIFO_PUSH = push;
  assign FIFO_POP  = pop;
  assign ACTIVE    = active;
  assign TC        = tc;
  assign FLUSHED   = flushed;
  assign INT       = tc & INTENA;

endmodule

// File: tb/tb_dma_sequencer.sv
// tb_dma_sequencer: directed vector table plus hand-written burst and
// timeout sequences for dma_sequencer.
module tb_dma_sequencer;

  logic        clk = 1'b0;
  logic        nrst;
  logic        st, sp, fl, clr, dmadir, intena;
  logic [23:0] wtc_in;
  logic [31:0] acr_in;
  logic        ffull, fempty, bg, bfree, done;
  logic        br, bgack, cyc_req, cyc_rw, push, pop;
  logic        active, tc, flushed, err, intr;
  logic [31:0] addr;
  logic [23:0] wtc;

  always #5 clk = ~clk;

  dma_sequencer #(
    .BURST_LEN(8),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .CLK(clk), ._RST(nrst),
    .ST_DMA(st), .SP_DMA(sp), .FLUSH(fl), .CLR_INT(clr),
    .DMADIR(dmadir), .INTENA(intena),
    .WTC_IN(wtc_in), .ACR_IN(acr_in),
    .FIFO_FULL(ffull), .FIFO_EMPTY(fempty),
    ._BG(bg), .BUS_FREE(bfree), .CYC_DONE(done),
    ._BR(br), ._BGACK(bgack), .CYC_REQ(cyc_req), .CYC_RW(cyc_rw),
    .ADDR_OUT(addr), .WTC_OUT(wtc),
    .FIFO_PUSH(push), .FIFO_POP(pop),
    .ACTIVE(active), .TC(tc), .FLUSHED(flushed), .ERR(err), .INT(intr)
  );

  // in : {st, sp, fl, clr, _bg, done, fifo_empty, bus_free}
  // ex : {_br, _bgack, req, push, pop, active, tc, flushed, int}
  typedef struct {
    int          c;
    logic [7:0]  in;
    logic [8:0]  ex;
    logic [31:0] a;
    logic [23:0] w;
  } vec_t;

  vec_t        vt[$];
  logic        cdir[4];
  logic        cint[4];
  logic        cff[4];
  logic [23:0] cw[4];
  logic [31:0] ca[4];
  int          nvec = 0;
  int          nbad = 0;

  function automatic void add(int c, logic [7:0] in, logic [8:0] ex,
                              logic [31:0] a, logic [23:0] w);
    vec_t t;
    t.c = c; t.in = in; t.ex = ex; t.a = a; t.w = w;
    vt.push_back(t);
  endfunction

  task automatic chk(string nm, logic [63:0] got, logic [63:0] want);
    nvec++;
    if (got !== want) begin
      nbad++;
      $display("FAIL %s got %h want %h", nm, got, want);
    end
  endtask

  task automatic cfg(logic d, logic ie, logic ff, logic [23:0] w,
                     logic [31:0] a);
    dmadir = d; intena = ie; ffull = ff; wtc_in = w; acr_in = a;
  endtask

  int cyc, ntn, nbr, nreq;
  int per[3];
  logic pb, pbr, seen;

  initial begin
    cdir = '{1'b1, 1'b1, 1'b0, 1'b0};
    cint = '{1'b1, 1'b0, 1'b1, 1'b1};
    cff  = '{1'b0, 1'b0, 1'b1, 1'b0};
    cw   = '{24'd3, 24'd0, 24'd5, 24'd10};
    ca   = '{32'h0010_0002, 32'h1234_5677, 32'h0000_2000, 32'h0000_3000};

    // read, 3 longwords, grant after 2 cycles, one cycle with BUS_FREE low
    add(0, 8'b1000_1011, 9'b110001000, 32'h0010_0000, 24'd3);
    add(0, 8'b0000_1011, 9'b010001000, 32'h0010_0000, 24'd3);
    add(0, 8'b0000_1011, 9'b010001000, 32'h0010_0000, 24'd3);
    add(0, 8'b0000_0010, 9'b010001000, 32'h0010_0000, 24'd3);
    add(0, 8'b0000_0011, 9'b100001000, 32'h0010_0000, 24'd3);
    add(0, 8'b0000_1011, 9'b101001000, 32'h0010_0000, 24'd3);
    add(0, 8'b0000_1011, 9'b101001000, 32'h0010_0000, 24'd3);
    add(0, 8'b0000_1111, 9'b100101000, 32'h0010_0004, 24'd2);
    add(0, 8'b0000_1011, 9'b101001000, 32'h0010_0004, 24'd2);
    add(0, 8'b0000_1111, 9'b100101000, 32'h0010_0008, 24'd1);
    add(0, 8'b0000_1011, 9'b101001000, 32'h0010_0008, 24'd1);
    add(0, 8'b0000_1111, 9'b100101000, 32'h0010_000C, 24'd0);
    add(0, 8'b0000_1011, 9'b110001101, 32'h0010_000C, 24'd0);
    add(0, 8'b0000_1011, 9'b110000101, 32'h0010_000C, 24'd0);
    add(0, 8'b0001_1011, 9'b110000000, 32'h0010_000C, 24'd0);
    // zero count: TC only, set beats clear, INTENA off
    add(1, 8'b1001_1011, 9'b110000100, 32'h1234_5674, 24'd0);
    add(1, 8'b0000_1011, 9'b110000100, 32'h1234_5674, 24'd0);
    add(1, 8'b0001_1011, 9'b110000000, 32'h1234_5674, 24'd0);
    add(1, 8'b0000_0011, 9'b110000000, 32'h1234_5674, 24'd0);
    // stop during the first cycle, then ST+SP, then stop in REQ
    add(2, 8'b1000_1001, 9'b110001000, 32'h0000_2000, 24'd5);
    add(2, 8'b0000_1001, 9'b010001000, 32'h0000_2000, 24'd5);
    add(2, 8'b0000_0001, 9'b100001000, 32'h0000_2000, 24'd5);
    add(2, 8'b0000_1001, 9'b101001000, 32'h0000_2000, 24'd5);
    add(2, 8'b0100_1001, 9'b101001000, 32'h0000_2000, 24'd5);
    add(2, 8'b0000_1101, 9'b100011000, 32'h0000_2004, 24'd4);
    add(2, 8'b0000_1001, 9'b110001000, 32'h0000_2004, 24'd4);
    add(2, 8'b0000_1001, 9'b110000000, 32'h0000_2004, 24'd4);
    add(2, 8'b1100_1001, 9'b110000000, 32'h0000_2004, 24'd4);
    add(2, 8'b1000_1001, 9'b110001000, 32'h0000_2000, 24'd5);
    add(2, 8'b0000_1001, 9'b010001000, 32'h0000_2000, 24'd5);
    add(2, 8'b0100_0001, 9'b110000000, 32'h0000_2000, 24'd5);
    // write flush with two entries, then flush while idle
    add(3, 8'b1000_1001, 9'b110001000, 32'h0000_3000, 24'd10);
    add(3, 8'b0000_1001, 9'b110001000, 32'h0000_3000, 24'd10);
    add(3, 8'b0010_1001, 9'b110001000, 32'h0000_3000, 24'd10);
    add(3, 8'b0000_1001, 9'b010001000, 32'h0000_3000, 24'd10);
    add(3, 8'b0000_0001, 9'b100001000, 32'h0000_3000, 24'd10);
    add(3, 8'b0000_1001, 9'b101001000, 32'h0000_3000, 24'd10);
    add(3, 8'b0000_1101, 9'b100011000, 32'h0000_3004, 24'd9);
    add(3, 8'b0000_1001, 9'b101001000, 32'h0000_3004, 24'd9);
    add(3, 8'b0000_1101, 9'b100011000, 32'h0000_3008, 24'd8);
    add(3, 8'b0000_1011, 9'b110001000, 32'h0000_3008, 24'd8);
    add(3, 8'b0000_1011, 9'b110001010, 32'h0000_3008, 24'd8);
    add(3, 8'b0000_1011, 9'b110001010, 32'h0000_3008, 24'd8);
    add(3, 8'b0001_1011, 9'b110001000, 32'h0000_3008, 24'd8);
    add(3, 8'b0100_1011, 9'b110000000, 32'h0000_3008, 24'd8);
    add(3, 8'b0010_1011, 9'b110000010, 32'h0000_3008, 24'd8);
    add(3, 8'b0011_1011, 9'b110000010, 32'h0000_3008, 24'd8);
    add(3, 8'b0001_1011, 9'b110000000, 32'h0000_3008, 24'd8);

    nrst = 1'b0;
    {st, sp, fl, clr, done} = '0;
    bg = 1'b1; bfree = 1'b1; fempty = 1'b1;
    cfg(1'b1, 1'b1, 1'b0, 24'd7, 32'hFFFF_FFFF);
    repeat (3) @(posedge clk);
    #1;
    chk("reset ctl",
        {br, bgack, cyc_req, push, pop, active, tc, flushed, intr, err},
        10'b1100000000);
    chk("reset addr", addr, 32'h0);
    chk("reset wtc", wtc, 24'h0);
    @(negedge clk);
    nrst = 1'b1;

    foreach (vt[i]) begin
      @(negedge clk);
      cfg(cdir[vt[i].c], cint[vt[i].c], cff[vt[i].c],
          cw[vt[i].c], ca[vt[i].c]);
      {st, sp, fl, clr, bg, done, fempty, bfree} = vt[i].in;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d ctl", i),
          {br, bgack, cyc_req, push, pop, active, tc, flushed, intr, err},
          {vt[i].ex, 1'b0});
      chk($sformatf("v%0d addr", i), addr, vt[i].a);
      chk($sformatf("v%0d wtc", i), wtc, vt[i].w);
    end

    // write, 20 longwords, FIFO held full: tenures of 8, 8 and 4
    @(negedge clk);
    {st, sp, fl, clr, done} = '0;
    bg = 1'b1; bfree = 1'b1; fempty = 1'b0;
    cfg(1'b0, 1'b1, 1'b1, 24'd20, 32'h0000_4000);
    st = 1'b1;
    @(negedge clk);
    st = 1'b0;
    cyc = 0; ntn = 0; nbr = 0; pb = 1'b1; pbr = 1'b1;
    per = '{0, 0, 0};
    while (active && cyc < 400) begin
      if (!bgack && pb) ntn++;
      if (!br && pbr) nbr++;
      if (pop && ntn >= 1 && ntn <= 3) per[ntn-1]++;
      pb = bgack; pbr = br;
      done = cyc_req;
      bg = br;
      @(negedge clk);
      cyc++;
    end
    done = 1'b0; bg = 1'b1;
    chk("burst bound", 64'(cyc < 400), 64'd1);
    chk("burst tenures", 64'(ntn), 64'd3);
    chk("burst br asserts", 64'(nbr), 64'd3);
    chk("burst t1", 64'(per[0]), 64'd8);
    chk("burst t2", 64'(per[1]), 64'd8);
    chk("burst t3", 64'(per[2]), 64'd4);
    chk("burst wtc", wtc, 24'd0);
    chk("burst addr", addr, 32'h0000_4050);
    chk("burst tc/int/bgack", {tc, intr, bgack}, 3'b111);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;

`ifdef DMA_TIMEOUT_EN
    // read cycle that never completes
    cfg(1'b1, 1'b1, 1'b0, 24'd3, 32'h0000_5000);
    fempty = 1'b1;
    st = 1'b1;
    @(negedge clk);
    st = 1'b0;
    cyc = 0; nreq = 0; seen = 1'b0;
    while (cyc < 100 && !(seen && !cyc_req)) begin
      if (cyc_req) begin
        seen = 1'b1;
        nreq++;
      end
      bg = br;
      @(negedge clk);
      cyc++;
    end
    bg = 1'b1;
    chk("to bound", 64'(cyc < 100), 64'd1);
    chk("to req cycles", 64'(nreq), 64'd16);
    chk("to err", {err, cyc_req, push}, 3'b100);
    @(negedge clk);
    chk("to release", {bgack, active, err}, 3'b101);
    chk("to addr", addr, 32'h0000_5000);
    chk("to wtc", wtc, 24'd3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
